// File: rtl/uart_pkg.sv
// Shared UART definitions used by the fast-link receive and transmit stages.
//   UART_DATA_BITS  - payload bits per frame
//   UART_FRAME_BITS - start + data + parity + stop
//   UART_IDLE_LEVEL - line level when no frame is in flight
//   uart_rx_state_t - receive FSM states
//   uart_parity()   - even parity of a payload byte
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 11;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_fast_read_if.sv
// Holding-register handshake between uart_fast_read and its consumer.
//   ack        - consumer takes the held byte this cycle (when valid=1)
//   word       - received byte
//   valid      - an unconsumed byte is held
//   parity_err - parity mismatch on the held byte
//   frame_err  - stop bit sampled low on the held byte
//   overrun    - a previous byte was overwritten before being acked
// Modports: master = receiver side, slave = consumer side.
interface uart_fast_read_if;
  import uart_pkg::*;

  logic                      ack;
  logic [UART_DATA_BITS-1:0] word;
  logic                      valid;
  logic                      parity_err;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    input  ack,
    output word, valid, parity_err, frame_err, overrun
  );

  modport slave (
    output ack,
    input  word, valid, parity_err, frame_err, overrun
  );

endinterface

// File: rtl/uart_fast_read_sync.sv
// Two-flop synchronizer for an asynchronous serial line. Both flops reset to
// the idle level so a reset never fabricates a start bit.
//   clk     - destination clock
//   reset_n - synchronous, active-low reset
//   d       - asynchronous line in
//   q       - line synchronized to clk (2 clocks of latency)
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_fast_read.sv
// Receive deserializer for the fast UART link. Frame: start 0, 8 data bits
// LSB first, even parity, stop 1. Each received byte lands in a holding
// register with parity/framing/overrun flags and a valid/ack handshake.
// Build option: define UART_FAST_READ_SYNC_EN to pass rxd through a 2-flop
// synchronizer (adds 2 clocks of latency) when rxd is asynchronous to clk.
//   clk     - system clock, posedge
//   reset_n - synchronous, active-low reset
//   rxd     - serial line, idle high
//   bus     - holding-register handshake (master side)
//   busy    - FSM is not idle
module uart_fast_read
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rxd,
  uart_fast_read_if.master bus,
  output logic             busy
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned CNT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_BIT  = TICK_W'(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  // With one clock per bit the start check coincides with the detect edge.
  localparam bit                SKIP_START = (CLKS_PER_BIT / 2) == 0;

  logic rx_line;

`ifdef UART_FAST_READ_SYNC_EN
  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rx_line)
  );
`else
  assign rx_line = rxd;
`endif

  uart_rx_state_t         state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d, tick_inc;
  logic [CNT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DATA_BITS-1:0]   word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  // Tick counts clocks since entering the state (or since the last sample).
  assign tick_inc = tick_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    word_d  = word_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (bus.ack && valid_q) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rx_line != UART_IDLE_LEVEL) begin
          bit_d   = '0;
          state_d = SKIP_START ? DATA : START;
        end
      end
      START: begin
        tick_d = tick_inc;
        if (tick_inc == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          // A high line at mid-start is a glitch: drop it without flags.
          state_d = (rx_line != UART_IDLE_LEVEL) ? DATA : IDLE;
        end
      end
      DATA: begin
        tick_d = tick_inc;
        if (tick_inc == TICK_BIT) begin
          tick_d  = '0;
          shift_d = {rx_line, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        tick_d = tick_inc;
        if (tick_inc == TICK_BIT) begin
          tick_d  = '0;
          par_d   = rx_line;
          state_d = STOP;
        end
      end
      STOP: begin
        tick_d = tick_inc;
        if (tick_inc == TICK_BIT) begin
          tick_d  = '0;
          // New byte wins over a same-cycle ack; overrun only if unacked.
          word_d  = shift_q;
          perr_d  = par_q != uart_parity(shift_q);
          ferr_d  = ~rx_line;
          ovr_d   = valid_q & ~bus.ack;
          valid_d = 1'b1;
          state_d = rx_line ? IDLE : BREAK;
        end
      end
      BREAK: begin
        tick_d = '0;
        if (rx_line == UART_IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end
      default: begin
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.word       = word_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign busy           = state_q != IDLE;

endmodule

// File: tb/tb_uart_fast_read.sv
// Bench for uart_fast_read: one instance at 1 clock/bit, one at 4 clocks/bit.
// Directed frames, a vector table, then random frame streams checked against
// a holding-register model.
module tb_uart_fast_read;
  import uart_pkg::*;

`ifdef UART_FAST_READ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int STREAM_LEN  = 2048;
  localparam int RAND_FRAMES = 30;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] rxd, ack, valid, perr, ferr, ovr, busy;
  logic [7:0] word [2];
  int         total = 0;
  int         bad   = 0;

  uart_fast_read_if u0 ();
  uart_fast_read_if u1 ();

  assign u0.ack  = ack[0];
  assign u1.ack  = ack[1];
  assign valid   = {u1.valid, u0.valid};
  assign perr    = {u1.parity_err, u0.parity_err};
  assign ferr    = {u1.frame_err, u0.frame_err};
  assign ovr     = {u1.overrun, u0.overrun};
  assign word[0] = u0.word;
  assign word[1] = u1.word;

  uart_fast_read #(.CLKS_PER_BIT(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .rxd     (rxd[0]),
    .bus     (u0),
    .busy    (busy[0])
  );

  uart_fast_read #(.CLKS_PER_BIT(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .rxd     (rxd[1]),
    .bus     (u1),
    .busy    (busy[1])
  );

  always #5 clk = ~clk;

  // Collects bytes consumed by ack on instance 0 (sampled mid-low-phase).
  logic       got_en = 1'b0;
  logic [7:0] got_word [$];
  logic [2:0] got_flag [$];
  always @(negedge clk) begin
    #2;
    if (got_en && valid[0] && ack[0]) begin
      got_word.push_back(word[0]);
      got_flag.push_back({perr[0], ferr[0], ovr[0]});
    end
  end

  function automatic int nbits(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < SYNC_LAT; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input int d, input string tag, input logic ev, input logic [7:0] ew,
                         input logic ep, input logic ef, input logic eo);
    chk($sformatf("%s.u%0d.valid", tag, d), 32'(valid[d]), 32'(ev));
    chk($sformatf("%s.u%0d.word", tag, d), 32'(word[d]), 32'(ew));
    chk($sformatf("%s.u%0d.parity_err", tag, d), 32'(perr[d]), 32'(ep));
    chk($sformatf("%s.u%0d.frame_err", tag, d), 32'(ferr[d]), 32'(ef));
    chk($sformatf("%s.u%0d.overrun", tag, d), 32'(ovr[d]), 32'(eo));
  endtask

  // Drives one bit period; early/late invert the line away from the mid sample.
  task automatic send_bit(input int d, input logic v, input logic early, input logic late);
    int nb;
    nb = nbits(d);
    for (int i = 0; i < nb; i++) begin
      if ((i < nb / 2 && early) || (i > nb / 2 && late)) rxd[d] = ~v;
      else rxd[d] = v;
      step();
    end
  endtask

  task automatic send_head(input int d, input logic [7:0] data, input logic par, input logic jit);
    send_bit(d, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send_bit(d, data[k], jit, jit);
    send_bit(d, par, jit, jit);
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                            input logic stop, input logic jit);
    send_head(d, data, par, jit);
    send_bit(d, stop, jit, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rxd     = 2'b11;
    ack     = 2'b00;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic ack_one(input int d);
    ack[d] = 1'b1;
    step();
    ack[d] = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] ew;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t tbl [7];

  logic       s_rx   [2][STREAM_LEN];
  logic       s_done [2][STREAM_LEN];
  logic [7:0] s_word [2][STREAM_LEN];
  logic       s_perr [2][STREAM_LEN];
  logic       s_ferr [2][STREAM_LEN];
  logic [1:0] m_valid, m_perr, m_ferr, m_ovr;
  logic [7:0] m_word [2];

  initial begin
    tbl[0] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[5] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk_out(d, "reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk($sformatf("reset.u%0d.busy", d), 32'(busy[d]), 32'd0);
    end

    // A5 at 1 clock/bit: nothing before the stop edge, byte right after it.
    send_head(0, 8'hA5, 1'b0, 1'b0);
    chk("a5.early.valid", 32'(valid[0]), 32'd0);
    chk("a5.early.busy", 32'(busy[0]), 32'd1);
    send_bit(0, 1'b1, 1'b0, 1'b0);
    settle();
    chk_out(0, "a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5.busy", 32'(busy[0]), 32'd0);
    ack_one(0);
    chk("a5.acked.valid", 32'(valid[0]), 32'd0);
    ack_one(0);
    chk("ack_idle.valid", 32'(valid[0]), 32'd0);

    // Vector table on the 1 clock/bit instance.
    for (int i = 0; i < 7; i++) begin
      step();
      send_frame(0, tbl[i].data, tbl[i].par, tbl[i].stop, 1'b0);
      rxd[0] = 1'b1;
      settle();
      chk_out(0, $sformatf("tbl%0d", i), 1'b1, tbl[i].ew, tbl[i].ep, tbl[i].ef, 1'b0);
      ack_one(0);
      chk($sformatf("tbl%0d.acked.valid", i), 32'(valid[0]), 32'd0);
    end

    // Back-to-back 00, FF, 3C with ack held high.
    step();
    got_en = 1'b1;
    ack[0] = 1'b1;
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    rxd[0] = 1'b1;
    for (int i = 0; i < 3 + SYNC_LAT; i++) step();
    got_en = 1'b0;
    ack[0] = 1'b0;
    chk("b2b.count", 32'(got_word.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b%0d.word", i), (i < got_word.size()) ? 32'(got_word[i]) : 32'hdead,
          (i == 0) ? 32'h00 : (i == 1) ? 32'hFF : 32'h3C);
      chk($sformatf("b2b%0d.flags", i), (i < got_flag.size()) ? 32'(got_flag[i]) : 32'hdead,
          32'd0);
    end

    // Stop bit low: BREAK holds off start detection until the line goes high.
    step();
    send_frame(0, 8'h01, 1'b1, 1'b0, 1'b0);
    rxd[0] = 1'b0;
    settle();
    chk_out(0, "brk", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("brk.hold.busy", 32'(busy[0]), 32'd1);
    rxd[0] = 1'b1;
    step();
    settle();
    chk("brk.exit.busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk_out(0, "brk.after", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    ack_one(0);

    // 4 clocks/bit: a one-clock glitch is dropped after the mid-start check.
    rxd[1] = 1'b0;
    step();
    rxd[1] = 1'b1;
    settle();
    chk("glitch.start.busy", 32'(busy[1]), 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("glitch.busy", 32'(busy[1]), 32'd0);
    chk("glitch.valid", 32'(valid[1]), 32'd0);
    // Line is only correct on tick 2 of each bit, so off-centre sampling fails.
    send_frame(1, 8'h5A, 1'b0, 1'b1, 1'b1);
    rxd[1] = 1'b1;
    settle();
    chk_out(1, "x4_5a", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    ack_one(1);

    // Overrun, then an ack landing on the completing edge.
    step();
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
    rxd[0] = 1'b1;
    settle();
    chk_out(0, "ovr11", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
    rxd[0] = 1'b1;
    settle();
    chk_out(0, "ovr22", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    send_head(0, 8'h33, 1'b0, 1'b0);
    rxd[0] = 1'b1;
    settle();
    ack_one(0);
    chk_out(0, "ovr33", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    ack_one(0);
    chk("ovr33.acked.valid", 32'(valid[0]), 32'd0);

    // Reset during d4 of a frame while a byte is held.
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(0, 1'(8'hA5 >> k), 1'b0, 1'b0);
    rxd[0]  = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rxd[0]  = 1'b1;
    chk_out(0, "midrst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midrst.busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 4; i++) step();
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b0);
    rxd[0] = 1'b1;
    settle();
    chk_out(0, "after_rst_7e", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);

    // Random frame streams on both instances with random ack.
    for (int d = 0; d < 2; d++) begin
      int   pos, nb, nf, done;
      logic prev_ferr, par, stop;
      logic [7:0]  data;
      logic [10:0] fr;
      nb = nbits(d);
      pos = 2;
      nf = 0;
      prev_ferr = 1'b0;
      for (int c = 0; c < STREAM_LEN; c++) begin
        s_rx[d][c]   = 1'b1;
        s_done[d][c] = 1'b0;
        s_word[d][c] = 8'h00;
        s_perr[d][c] = 1'b0;
        s_ferr[d][c] = 1'b0;
      end
      while (nf < RAND_FRAMES && pos + 12 * nb + SYNC_LAT + 8 < STREAM_LEN) begin
        pos += int'($urandom_range(3, prev_ferr ? 1 : 0));
        data = 8'($urandom);
        par  = (^data) ^ ($urandom_range(3, 0) == 0);
        stop = $urandom_range(4, 0) != 0;
        fr   = {stop, par, data, 1'b0};
        for (int k = 0; k < 11; k++)
          for (int j = 0; j < nb; j++) s_rx[d][pos + k * nb + j] = fr[k];
        done = pos + 10 * nb + nb / 2 + SYNC_LAT;
        s_done[d][done] = 1'b1;
        s_word[d][done] = data;
        s_perr[d][done] = par != ^data;
        s_ferr[d][done] = ~stop;
        prev_ferr = ~stop;
        pos += 11 * nb;
        nf++;
      end
    end

    do_reset();
    m_valid = '0;
    m_perr  = '0;
    m_ferr  = '0;
    m_ovr   = '0;
    m_word[0] = 8'h00;
    m_word[1] = 8'h00;
    for (int c = 0; c < STREAM_LEN; c++) begin
      for (int d = 0; d < 2; d++) begin
        rxd[d] = s_rx[d][c];
        ack[d] = $urandom_range(2, 0) == 0;
        if (s_done[d][c]) begin
          m_ovr[d]   = m_valid[d] & ~ack[d];
          m_valid[d] = 1'b1;
          m_word[d]  = s_word[d][c];
          m_perr[d]  = s_perr[d][c];
          m_ferr[d]  = s_ferr[d][c];
        end else if (ack[d] && m_valid[d]) begin
          m_valid[d] = 1'b0;
        end
      end
      step();
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d]) begin
          chk_out(d, $sformatf("rnd.c%0d", c), 1'b1, m_word[d], m_perr[d], m_ferr[d], m_ovr[d]);
        end else begin
          chk($sformatf("rnd.c%0d.u%0d.valid", c, d), 32'(valid[d]), 32'd0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
